// File: rtl/uart_pkg.sv
// Shared UART definitions: frame decoder state encoding, default SOF marker
// and the inter-byte timeout computation.
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } frame_state_t;

    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;

    // Clock cycles in TIMEOUT_BITS bit-times at the given line rate.
    function automatic int timeout_clks(input int clk_f, input int baud, input int bits);
        return (clk_f / baud) * bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, combinational read.
`default_nettype none
`timescale 1ns/1ps

module uart_frame_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/uart_frame_decoder.sv
// Frame parser [SOF][LEN][PAYLOAD][CHK] behind a UART receiver; buffers the
// payload and releases it as a valid/ready stream once the XOR checksum passes.
`default_nettype none
`timescale 1ns/1ps

module uart_frame_decoder
    import uart_pkg::*;
#(
    parameter int         CLK_F        = 50_000_000,
    parameter int         BAUD         = 9600,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SOF_BYTE     = SOF_BYTE_DEF,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_last,
    input  logic        i_ready,
    output logic        o_err_len,
    output logic        o_err_chk,
    output logic        o_err_timeout,
    output logic        o_drop,
    output logic [15:0] o_frame_cnt,
    output logic [2:0]  t_state
);

    localparam int TIMEOUT_CLKS = timeout_clks(CLK_F, BAUD, TIMEOUT_BITS);
    localparam int TO_W         = $clog2(TIMEOUT_CLKS);
    localparam int PTR_W        = $clog2(MAX_LEN + 1);
    localparam int ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t     state_q;
    logic [PTR_W-1:0] len_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [7:0]       chk_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             valid_q;
    logic             err_len_q;
    logic             err_chk_q;
    logic             err_to_q;
    logic             drop_q;
    logic [15:0]      frame_cnt_q;

    logic [PTR_W-1:0] last_idx;
    logic             active;
    logic             expire;
    logic             buf_we;
    logic [7:0]       buf_rdata;

    assign last_idx = len_q - PTR_W'(1);
    assign active   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    // An arriving byte always beats a coincident expiry.
    assign expire   = active && !i_valid && (to_cnt_q == TO_LAST);
    assign buf_we   = (state_q == ST_PAYLOAD) && i_valid;

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (i_data),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            chk_q       <= '0;
            to_cnt_q    <= '0;
            valid_q     <= 1'b0;
            err_len_q   <= 1'b0;
            err_chk_q   <= 1'b0;
            err_to_q    <= 1'b0;
            drop_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            err_len_q <= 1'b0;
            err_chk_q <= 1'b0;
            err_to_q  <= 1'b0;
            drop_q    <= 1'b0;
            to_cnt_q  <= (active && !i_valid && !expire) ? to_cnt_q + TO_W'(1) : '0;

            if (expire) begin
                err_to_q <= 1'b1;
                state_q  <= ST_IDLE;
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_valid && (i_data == SOF_BYTE)) begin
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_valid) begin
                        len_q    <= i_data[PTR_W-1:0];
                        chk_q    <= i_data;
                        wr_ptr_q <= '0;
                        if ((i_data != 8'd0) && (i_data <= MAX_LEN_B)) begin
                            state_q <= ST_PAYLOAD;
                        end else begin
                            err_len_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (i_valid) begin
                        chk_q    <= chk_q ^ i_data;
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        if (wr_ptr_q == last_idx) begin
                            state_q <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (i_valid) begin
                        if (i_data == chk_q) begin
                            state_q     <= ST_DRAIN;
                            rd_ptr_q    <= '0;
                            valid_q     <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end else begin
                            err_chk_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (i_valid) begin
                        drop_q <= 1'b1;
                    end
                    if (i_ready) begin
                        if (rd_ptr_q == last_idx) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The data array has no reset, so mask the read port outside DRAIN.
    assign o_valid       = valid_q;
    assign o_data        = valid_q ? buf_rdata : 8'd0;
    assign o_last        = valid_q && (rd_ptr_q == last_idx);
    assign o_err_len     = err_len_q;
    assign o_err_chk     = err_chk_q;
    assign o_err_timeout = err_to_q;
    assign o_drop        = drop_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign t_state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
// Directed scoreboard bench for uart_frame_decoder (short timeout: 40 clocks).
`default_nettype none
`timescale 1ns/1ps

module tb_uart_frame_decoder;

    localparam int TO = (1000 / 100) * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [7:0]  i_data = 8'd0;
    logic        i_ready = 1'b1;
    logic        o_valid, o_last, o_err_len, o_err_chk, o_err_timeout, o_drop;
    logic [7:0]  o_data;
    logic [15:0] o_frame_cnt;
    logic [2:0]  t_state;

    int n_tests = 0;
    int n_fail  = 0;
    int n_hs = 0, n_elen = 0, n_echk = 0, n_eto = 0, n_drop = 0;
    logic [8:0] sb[$];
    logic       hold_pending = 1'b0;
    logic [8:0] held;

    uart_frame_decoder #(
        .CLK_F        (1000),
        .BAUD         (100),
        .MAX_LEN      (16),
        .SOF_BYTE     (8'hA5),
        .TIMEOUT_BITS (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .i_ready       (i_ready),
        .o_err_len     (o_err_len),
        .o_err_chk     (o_err_chk),
        .o_err_timeout (o_err_timeout),
        .o_drop        (o_drop),
        .o_frame_cnt   (o_frame_cnt),
        .t_state       (t_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops, stall-hold checks, error pulse counting.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold", {o_valid, o_last, o_data}, {1'b1, held});
            end
            hold_pending = o_valid && !i_ready;
            held = {o_last, o_data};
            if (o_valid && i_ready) begin
                n_hs++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {o_last, o_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("beat", {o_last, o_data}, sb.pop_front());
                end
            end
            if (o_err_len)     n_elen++;
            if (o_err_chk)     n_echk++;
            if (o_err_timeout) n_eto++;
            if (o_drop)        n_drop++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Sends a well-formed frame of n (1..3) payload bytes; the bench computes the checksum.
    task automatic send_good(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] pl[3];
        logic [7:0] acc;
        pl  = '{b0, b1, b2};
        acc = n[7:0];
        for (int i = 0; i < n; i++) begin
            acc = acc ^ pl[i];
            sb.push_back({(i == n - 1), pl[i]});
        end
        send_byte(8'hA5);
        send_byte(n[7:0]);
        for (int i = 0; i < n; i++) send_byte(pl[i]);
        send_byte(acc);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && (sb.size() != 0 || o_valid); i++) tick();
        chk(tag, {31'd0, (sb.size() == 0 && !o_valid)}, 32'd1);
    endtask

    initial begin
        int hs0;
        // Reset state
        repeat (3) tick();
        chk("reset_outputs", {o_valid, o_last, o_data, o_err_len, o_err_chk, o_err_timeout, o_drop}, 32'd0);
        chk("reset_cnt_state", {o_frame_cnt, 13'd0, t_state}, 32'd0);
        rst = 1'b0;
        tick();

        // 1. Good frame, always ready; o_valid rises right after the CHK edge
        hs0 = n_hs;
        send_good(3, 8'h11, 8'h22, 8'h33);
        chk("latency_valid", {31'd0, o_valid}, 32'd1);
        chk("drain_state", {29'd0, t_state}, 32'd4);
        wait_drain("t1_drain");
        chk("t1_handshakes", n_hs - hs0, 3);
        chk("t1_frame_cnt", {16'd0, o_frame_cnt}, 32'd1);
        chk("t1_no_errors", n_elen + n_echk + n_eto + n_drop, 0);

        // 2. Backpressure pattern 1,0,0,1,...
        i_ready = 1'b0;
        hs0 = n_hs;
        send_good(3, 8'h11, 8'h22, 8'h33);
        for (int k = 0; k < 60 && (sb.size() != 0 || o_valid); k++) begin
            i_ready = ((k % 4) == 0) || ((k % 4) == 3);
            tick();
        end
        i_ready = 1'b1;
        wait_drain("t2_drain");
        chk("t2_handshakes", n_hs - hs0, 3);
        chk("t2_frame_cnt", {16'd0, o_frame_cnt}, 32'd2);

        // 3. Bad checksum, then recovery
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h00);
        chk("t3_err_chk_pulse", {31'd0, o_err_chk}, 32'd1);
        chk("t3_idle", {29'd0, t_state}, 32'd0);
        tick();
        chk("t3_err_chk_once", {31'd0, o_err_chk}, 32'd0);
        chk("t3_frame_cnt", {16'd0, o_frame_cnt}, 32'd2);
        send_good(2, 8'h01, 8'h02, 8'h00);
        wait_drain("t3_drain");
        chk("t3_frame_cnt_after", {16'd0, o_frame_cnt}, 32'd3);

        // 4. Length errors, then SOF-valued payload
        send_byte(8'hA5); send_byte(8'h00);
        chk("t4_len0", {31'd0, o_err_len}, 32'd1);
        send_byte(8'hA5); send_byte(8'h11);
        chk("t4_len17", {31'd0, o_err_len}, 32'd1);
        tick();
        chk("t4_err_len_count", n_elen, 2);
        send_good(1, 8'hA5, 8'h00, 8'h00);
        chk("t4_single_last", {o_valid, o_last, o_data}, {2'b11, 8'hA5});
        wait_drain("t4_drain");
        chk("t4_frame_cnt", {16'd0, o_frame_cnt}, 32'd4);

        // 5. Timeout after TO idle clocks; then a byte exactly at expiry wins
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        repeat (TO - 1) tick();
        chk("t5_pre_expiry", {o_err_timeout, 28'd0, t_state}, 32'd2);
        tick();
        chk("t5_timeout_pulse", {o_err_timeout, 28'd0, t_state}, {1'b1, 31'd0});
        tick();
        chk("t5_timeout_once", n_eto, 1);
        sb.push_back({1'b0, 8'h10});
        sb.push_back({1'b1, 8'h20});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        repeat (TO - 1) tick();
        send_byte(8'h20);
        chk("t5_byte_wins", {o_err_timeout, 28'd0, t_state}, 32'd3);
        send_byte(8'h02 ^ 8'h10 ^ 8'h20);
        wait_drain("t5_drain");
        chk("t5_timeout_total", n_eto, 1);
        chk("t5_frame_cnt", {16'd0, o_frame_cnt}, 32'd5);

        // 6. Overrun while stalled in DRAIN
        i_ready = 1'b0;
        send_good(2, 8'h66, 8'h77, 8'h00);
        repeat (2) tick();
        send_byte(8'h55);
        chk("t6_drop_pulse", {o_drop, o_valid, 19'd0, t_state, o_data}, {2'b11, 19'd0, 3'd4, 8'h66});
        tick();
        chk("t6_drop_once", n_drop, 1);
        i_ready = 1'b1;
        wait_drain("t6_drain");
        chk("t6_frame_cnt", {16'd0, o_frame_cnt}, 32'd6);

        // Reset mid-PAYLOAD, then a fresh frame
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
        rst = 1'b1;
        #2;
        chk("rst_outputs", {o_valid, o_last, o_data, o_err_len, o_err_chk, o_err_timeout, o_drop}, 32'd0);
        chk("rst_cnt_state", {o_frame_cnt, 13'd0, t_state}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_good(1, 8'h5A, 8'h00, 8'h00);
        wait_drain("rst_drain");
        chk("rst_frame_cnt", {16'd0, o_frame_cnt}, 32'd1);
        chk("final_errors", {n_elen[7:0], n_echk[7:0], n_eto[7:0], n_drop[7:0]}, 32'h02010101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
